// File: rtl/gamma_cycle_sched_if.sv
// Control/result bundle between gamma_cycle_sched, the network start/done control
// and the bank of temporal lanes it sequences.
interface gamma_cycle_sched_if #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_LANES         = 4
);
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH) + 1;
  localparam int IW = $clog2(NUM_LANES);

  logic                    start;
  logic [NUM_LANES-1:0]    lane_q;
  logic                    lane_rst;
  logic                    busy;
  logic                    done;
  logic [NUM_LANES*TW-1:0] spike_time;
  logic [NUM_LANES-1:0]    spike_valid;
  logic [IW-1:0]           winner_idx;
  logic                    winner_valid;

  modport master (
    output start, lane_q,
    input  lane_rst, busy, done, spike_time, spike_valid, winner_idx, winner_valid
  );

  modport slave (
    input  start, lane_q,
    output lane_rst, busy, done, spike_time, spike_valid, winner_idx, winner_valid
  );
endinterface

// File: rtl/gamma_cycle_sched.sv
// Gamma-cycle sequencer: clear lanes, time the compute window, capture first spikes,
// resolve the earliest lane. Define GAMMA_AUTO_RESTART_EN for free-running cycles.
module gamma_cycle_sched #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_LANES         = 4,
  parameter int CLR_CYCLES        = 2
) (
  input  logic               aclk,
  input  logic               grst_n,
  gamma_cycle_sched_if.slave sif
);
  localparam int TW      = $clog2(GAMMA_CYCLE_WIDTH) + 1;
  localparam int IW      = $clog2(NUM_LANES);
  localparam int CNT_MAX = (GAMMA_CYCLE_WIDTH > CLR_CYCLES) ? GAMMA_CYCLE_WIDTH : CLR_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [TW-1:0] T_INF    = TW'(GAMMA_CYCLE_WIDTH);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COMPUTE, S_RESOLVE, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_cnt;
  logic                    w_clr_exit;
  logic                    w_cmp_last;
  logic                    r_lane_rst;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_lane_rst_next;
  logic                    w_busy_next;
  logic                    w_done_next;
  logic [TW-1:0]           r_spike_time [NUM_LANES];
  logic [NUM_LANES-1:0]    r_spike_valid;
  logic [IW-1:0]           r_winner_idx;
  logic                    r_winner_valid;
  logic [IW-1:0]           w_best_idx;
  logic [TW-1:0]           w_best_time;
  logic                    w_best_any;
  logic [NUM_LANES*TW-1:0] w_spike_time_flat;

  assign w_clr_exit = (r_state == S_CLEAR)   && (r_cnt == CLR_LAST);
  assign w_cmp_last = (r_state == S_COMPUTE) && (r_cnt == CYC_LAST);

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clr_exit || w_cmp_last || ((r_state != S_CLEAR) && (r_state != S_COMPUTE)))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (sif.start) w_state_next = S_CLEAR;
      S_CLEAR:   if (w_clr_exit) w_state_next = S_COMPUTE;
      S_COMPUTE: if (w_cmp_last) w_state_next = S_RESOLVE;
      S_RESOLVE: w_state_next = S_DONE;
`ifdef GAMMA_AUTO_RESTART_EN
      S_DONE:    w_state_next = S_CLEAR;
`else
      S_DONE:    w_state_next = S_IDLE;
`endif
      default:   w_state_next = S_IDLE;
    endcase
  end

  // lane_rst tracks the state it frames; busy/done trail the state by one edge so
  // done rises only once the resolved winner is already in its register.
  always_comb begin
    w_lane_rst_next = (w_state_next == S_CLEAR);
    w_busy_next     = (r_state == S_CLEAR) || (r_state == S_COMPUTE) || (r_state == S_RESOLVE);
    w_done_next     = (r_state == S_DONE);
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_lane_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_lane_rst <= w_lane_rst_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  // Results are wiped on the last clear edge so they stay readable during done,
  // even when the next cycle starts immediately.
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < NUM_LANES; i++) r_spike_time[i] <= T_INF;
      r_spike_valid <= '0;
    end else if (w_clr_exit) begin
      for (int i = 0; i < NUM_LANES; i++) r_spike_time[i] <= T_INF;
      r_spike_valid <= '0;
    end else if (r_state == S_COMPUTE) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sif.lane_q[i] && !r_spike_valid[i]) begin
          r_spike_time[i]  <= TW'(r_cnt);
          r_spike_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_best_idx  = '0;
    w_best_time = T_INF;
    w_best_any  = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (r_spike_valid[i] && (!w_best_any || (r_spike_time[i] < w_best_time))) begin
        w_best_idx  = IW'(i);
        w_best_time = r_spike_time[i];
        w_best_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_winner_idx   <= '0;
      r_winner_valid <= 1'b0;
    end else if (w_clr_exit) begin
      r_winner_valid <= 1'b0;
    end else if (r_state == S_RESOLVE) begin
      r_winner_idx   <= w_best_idx;
      r_winner_valid <= w_best_any;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_flat
    assign w_spike_time_flat[gi*TW +: TW] = r_spike_time[gi];
  end

  assign sif.lane_rst     = r_lane_rst;
  assign sif.busy         = r_busy;
  assign sif.done         = r_done;
  assign sif.spike_time   = w_spike_time_flat;
  assign sif.spike_valid  = r_spike_valid;
  assign sif.winner_idx   = r_winner_idx;
  assign sif.winner_valid = r_winner_valid;
endmodule

// File: tb/tb_gamma_cycle_sched.sv
// Bench for gamma_cycle_sched: timeline model of the gamma cycle compared every
// cycle, directed scenarios with literal expectations, then randomized cycles.
module tb_gamma_cycle_sched;
  localparam int G   = 16;
  localparam int NL  = 4;
  localparam int CLR = 2;
  localparam int TW  = 5;
  localparam int P   = CLR + G + 2;
  localparam logic [NL*TW-1:0] ALL_INF = {NL{5'd16}};

  logic clk = 1'b0;
  logic grst_n = 1'b0;
  always #5 clk = ~clk;

  gamma_cycle_sched_if #(.GAMMA_CYCLE_WIDTH(G), .NUM_LANES(NL)) sif ();

  gamma_cycle_sched #(
    .GAMMA_CYCLE_WIDTH(G),
    .NUM_LANES(NL),
    .CLR_CYCLES(CLR)
  ) dut (
    .aclk(clk),
    .grst_n(grst_n),
    .sif(sif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Timeline model: a cycle accepted at edge t0 is described purely by k = edge - t0.
  int          edge_n = 0;
  bit          active = 1'b0;
  int          t0 = 0;
  int          m_k = -1;
  bit          exp_lane_rst = 1'b1;
  bit          exp_busy = 1'b0;
  bit          exp_done = 1'b0;
  int          m_time [NL] = '{default: G};
  bit [NL-1:0] m_valid = '0;
  int          m_widx = 0;
  bit          m_wvalid = 1'b0;
  int          m_best;

  always @(posedge clk or negedge grst_n) begin
    if (!grst_n) begin
      active = 1'b0; exp_lane_rst = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      for (int i = 0; i < NL; i++) m_time[i] = G;
      m_valid = '0; m_widx = 0; m_wvalid = 1'b0;
    end else begin
      edge_n++;
      exp_done = 1'b0;
      if (active && (edge_n - t0 == P)) begin
        exp_done = 1'b1;
`ifdef GAMMA_AUTO_RESTART_EN
        t0 = edge_n;
`else
        active = 1'b0;
`endif
      end else if (!active && sif.start) begin
        active = 1'b1;
        t0 = edge_n;
      end
      m_k = active ? (edge_n - t0) : -1;
      if (m_k == CLR) begin
        for (int i = 0; i < NL; i++) m_time[i] = G;
        m_valid = '0; m_wvalid = 1'b0;
      end
      if (m_k >= CLR + 1 && m_k <= CLR + G) begin
        for (int i = 0; i < NL; i++)
          if (sif.lane_q[i] && !m_valid[i]) begin
            m_time[i] = m_k - CLR - 1;
            m_valid[i] = 1'b1;
          end
      end
      if (m_k == CLR + G + 1) begin
        m_best = G;
        for (int i = 0; i < NL; i++) if (m_valid[i] && m_time[i] < m_best) m_best = m_time[i];
        m_wvalid = (m_valid != '0);
        m_widx = 0;
        for (int i = NL - 1; i >= 0; i--) if (m_valid[i] && m_time[i] == m_best) m_widx = i;
      end
      exp_lane_rst = (m_k >= 0) && (m_k < CLR);
      exp_busy     = (m_k >= 1) && (m_k <= CLR + G + 1);
    end
  end

  logic [NL*TW-1:0] exp_flat;
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) exp_flat[i*TW +: TW] = TW'(m_time[i]);
    if (sif.done === 1'b1) n_done_seen++;
    chk("lane_rst", 32'(sif.lane_rst), 32'(exp_lane_rst));
    chk("busy", 32'(sif.busy), 32'(exp_busy));
    chk("done", 32'(sif.done), 32'(exp_done));
    chk("spike_time", 32'(sif.spike_time), 32'(exp_flat));
    chk("spike_valid", 32'(sif.spike_valid), 32'(m_valid));
    chk("winner_valid", 32'(sif.winner_valid), 32'(m_wvalid));
    chk("winner_idx", 32'(sif.winner_idx), 32'(m_widx));
  end

  int rise_t [NL];

  // Caller is #1 after an edge with the DUT idle; start is sampled at the next edge (t0).
  task automatic run_gamma(input bit hold_start, input bit rnd, input int rst_at, input bit pin_done);
    int c;
    sif.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) sif.start = 1'b0;
    for (int k = 0; k <= P; k++) begin
      c = k - CLR;
      if (hold_start && k == CLR + 5) sif.start = 1'b0;
      if (rnd && k >= 1 && k < P) sif.start = ($urandom_range(0, 3) == 0);
      if (k == P) sif.start = 1'b0;
      for (int i = 0; i < NL; i++)
        sif.lane_q[i] = rnd ? ($urandom_range(0, 5) == 0) : (c >= rise_t[i]);
      if (pin_done && k == P) chk("done_latency", 32'(sif.done), 32'd1);
      if (k == rst_at) begin
        grst_n = 1'b0;
        sif.start = 1'b0;
        #1;
        chk("async_rst_busy", 32'(sif.busy), 32'd0);
        chk("async_rst_lane_rst", 32'(sif.lane_rst), 32'd1);
        @(posedge clk); #1;
        grst_n = 1'b1;
        sif.lane_q = '0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    sif.lane_q = '0;
  endtask

  int d0;

  initial begin
    sif.start = 1'b0;
    sif.lane_q = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lane_rst", 32'(sif.lane_rst), 32'd1);
    chk("rst_spike_time", 32'(sif.spike_time), 32'(ALL_INF));
    chk("rst_done", 32'(sif.done), 32'd0);
    grst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_lane_rst", 32'(sif.lane_rst), 32'd0);

`ifndef GAMMA_AUTO_RESTART_EN
    rise_t = '{G + 5, G + 5, 5, G + 5};
    run_gamma(1'b0, 1'b0, -1, 1'b1);
    chk("single_time2", 32'(sif.spike_time[2*TW +: TW]), 32'd5);
    chk("single_model_time2", 32'(m_time[2]), 32'd5);
    chk("single_valid", 32'(sif.spike_valid), 32'b0100);
    chk("single_widx", 32'(sif.winner_idx), 32'd2);
    chk("single_wvalid", 32'(sif.winner_valid), 32'd1);

    rise_t = '{9, 7, G + 5, 7};
    run_gamma(1'b0, 1'b0, -1, 1'b1);
    chk("tie_times", 32'(sif.spike_time), 32'({5'd7, 5'd16, 5'd7, 5'd9}));
    chk("tie_valid", 32'(sif.spike_valid), 32'b1011);
    chk("tie_widx", 32'(sif.winner_idx), 32'd1);
    chk("tie_model_widx", 32'(m_widx), 32'd1);

    rise_t = '{G + 5, G + 5, G + 5, G + 5};
    run_gamma(1'b0, 1'b0, -1, 1'b1);
    chk("none_wvalid", 32'(sif.winner_valid), 32'd0);
    chk("none_widx", 32'(sif.winner_idx), 32'd0);
    chk("none_times", 32'(sif.spike_time), 32'(ALL_INF));

    rise_t = '{G, G, G, G};
    run_gamma(1'b0, 1'b0, -1, 1'b1);
    chk("late_wvalid", 32'(sif.winner_valid), 32'd0);
    chk("late_times", 32'(sif.spike_time), 32'(ALL_INF));

    rise_t = '{0, 3, G + 5, G - 1};
    run_gamma(1'b0, 1'b0, -1, 1'b1);
    chk("edge_times", 32'(sif.spike_time), 32'({5'd15, 5'd16, 5'd3, 5'd0}));
    chk("edge_widx", 32'(sif.winner_idx), 32'd0);

    d0 = n_done_seen;
    rise_t = '{4, 6, 8, 10};
    run_gamma(1'b1, 1'b0, -1, 1'b1);
    chk("hold_start_dones", 32'(n_done_seen - d0), 32'd1);

    d0 = n_done_seen;
    rise_t = '{2, G + 5, G + 5, G + 5};
    run_gamma(1'b0, 1'b0, CLR + 4, 1'b0);
    repeat (P) @(posedge clk);
    #1;
    chk("rst_mid_dones", 32'(n_done_seen - d0), 32'd0);
    chk("rst_mid_valid", 32'(sif.spike_valid), 32'd0);
    chk("rst_mid_times", 32'(sif.spike_time), 32'(ALL_INF));

    rise_t = '{1, 1, 1, 1};
    run_gamma(1'b0, 1'b0, -1, 1'b1);
    chk("after_rst_times", 32'(sif.spike_time), 32'({5'd1, 5'd1, 5'd1, 5'd1}));
    chk("after_rst_widx", 32'(sif.winner_idx), 32'd0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NL; i++) rise_t[i] = $urandom_range(0, G + 3);
      run_gamma(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
`else
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    d0 = n_done_seen;
    for (int k = 0; k < 4 * P + 1; k++) begin
      for (int i = 0; i < NL; i++) sif.lane_q[i] = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    sif.lane_q = '0;
    chk("auto_done_count", 32'(n_done_seen - d0), 32'd4);
`endif

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
